max_pool_layer: RTL
===================

Name: max_pool_layer

Overview:
- Streaming 2x2/stride-2 pooling stage directly downstream of the convolution layer.
- Consumes the per-engine raster-order result stream (one value per engine per valid beat) and emits one pooled value per engine per 2x2 window.
- The output is a raster-order stream of floor(W/2) x floor(H/2) values that feeds the RAM/buffer writeback stage.
- All engines are pooled in lock-step from a shared valid.

Parameters:
- MaxMatrixSize, 16383: largest input row width W accepted. The line buffer depth is MaxMatrixSize/2.
- EngineCount, 1023: number of parallel channels, matching the convolution layer.
- N, 16: signed data width.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous, active-high reset
- en_i  input  1  stage enable; when low, all state holds and inputs are ignored
- matrix_size_i  input  14  input row width W (= convolution output width); sampled at frame start
- data_i  input  N x EngineCount  signed input values
- valid_i  input  1  data_i valid this cycle
- done_i  input  1  upstream frame complete
- data_o  output  N x EngineCount  signed pooled values
- valid_o  output  1  data_o valid
- done_o  output  1  frame pooled and drained

Behaviour:
Reset and interface rules:
- Reset is asynchronous and active-high. The design has one clock, clk_i.
- On reset: data_o = 0, valid_o = 0, done_o = 0, state = IDLE, counters = 0.
- Reset mid-frame aborts the frame. No partial output is emitted afterwards.
- There is no backpressure. Downstream must accept every valid_o beat.
- Bubbles (valid_i low) are allowed anywhere in the stream.

State machine: IDLE -> EVEN_ROW <-> ODD_ROW -> DONE.
- IDLE: the first valid_i && en_i latches W = matrix_size_i and enters EVEN_ROW. That beat is processed as column 0.
- col counts valid beats in the current row and wraps to 0 at W-1, toggling between EVEN_ROW and ODD_ROW.
- Beats with col[0] = 0 load pair_reg[e] = data_i[e].
- Beats with col[0] = 1 and col < 2*floor(W/2) form hmax = max(pair_reg, data_i) as a signed compare.
  - In EVEN_ROW, hmax is written to line_buf[col>>1].
  - In ODD_ROW, out = max(hmax, line_buf[col>>1]) is registered to data_o, with valid_o high for exactly one cycle.
  - Latency: valid_o rises on the clk_i edge after the completing input beat.
- Odd W: the last column of each row is discarded.
- Odd H: the trailing even row is written to the line buffer but never emitted.
- W < 2: no outputs are produced. done_o still follows done_i.
- done_i observed in any non-IDLE state, or in IDLE: enter DONE once any pending valid_o has been issued.
  - done_o is asserted the cycle after entry and held until reset.
  - done_i on the same cycle as the final valid_i: the final beat is processed first, and done_o asserts one cycle after the last valid_o.
- DONE ignores valid_i.
- data_o holds its last value when valid_o is low.

Line buffer:
- One entry per output column, N*EngineCount bits wide.
- Read and write use the same address in different row parities, so no read-during-write hazard arises.
- May be inferred as BRAM with a 1-cycle read. The read address is presented one beat early, at col|1 on the pair-load beat.

Optional Feature:
Macro AVG_POOL_EN.
- Defined:
  - Adds input port pool_mode_i (1 bit, sampled at frame start): 0 = max, 1 = average.
  - Average = (a+b+c+d) >>> 2, computed in N+2 bits, arithmetic shift (floor toward -inf), truncated to N bits.
  - In average mode, the line buffer stores the N+1-bit horizontal sum.
- Undefined: the port is absent and the stage is max-only, with N-bit line buffer entries.

Decomposition:
- Package pool_pkg:
  - pool_state_t enum {IDLE, EVEN_ROW, ODD_ROW, DONE}
  - LineBufDepth(MaxMatrixSize) constant function
  - signed max2 function
- Sub-module pool_line_buffer: simple dual-port RAM, depth MaxMatrixSize/2, width EngineCount x (N or N+1), 1-cycle read latency.

Test Plan:
- W=4, engine0 data = 0..15 raster, engine1 = -i -> engine0 outputs 5, 7, 13, 15; engine1 outputs 0, -2, -8, -10. Exactly 4 valid_o pulses, each 1 cycle after beats 5, 7, 13, 15. done_o 1 cycle after the last output.
- W=5, data 0..24 -> outputs 6, 8, 16, 18. Column 4 and row 4 are dropped, and there is no extra valid_o.
- W=4, data 0..15 with a bubble inserted after every input beat -> same values 5, 7, 13, 15, each 1 cycle after its completing beat.
- Reset asserted asynchronously after beat 9 of a W=4 frame, then a new frame of 100..115 -> outputs 105, 107, 113, 115 only; done_o low until the new done_i.
- en_i low for 3 cycles mid-row -> state frozen; no output changes; results are identical to the run with en_i constantly high.
- AVG_POOL_EN defined, pool_mode_i=1, W=4, data 0..15 -> 2, 4, 10, 12.
- AVG_POOL_EN defined, pool_mode_i=1, W=4, data -(0..15) -> -3, -5, -11, -13.

Source files
------------

// File: rtl/pool_pkg.sv
// pool_pkg
// Shared types and helpers for the 2x2/stride-2 pooling stage.
//   pool_state_t  frame-level FSM states (IDLE, EVEN_ROW, ODD_ROW, DONE)
//   LineBufDepth  line buffer entries needed for a given maximum row width
//   AddrWidth     address width for a RAM of a given depth (at least 1)
//   max2          signed maximum of two values, evaluated at MaxDataW bits
package pool_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EVEN_ROW,
        ODD_ROW,
        DONE
    } pool_state_t;

    // Width of the row-size port and the column counter.
    localparam int SizeW = 14;

    // Working width of max2; callers sign-extend into it and truncate back.
    localparam int MaxDataW = 32;

    // One entry per output column. A row of W inputs yields floor(W/2) columns.
    function automatic int LineBufDepth(input int maxMatrixSize);
        return (maxMatrixSize / 2 > 0) ? maxMatrixSize / 2 : 1;
    endfunction

    function automatic int AddrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic logic signed [MaxDataW-1:0] max2(
        input logic signed [MaxDataW-1:0] a,
        input logic signed [MaxDataW-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// pool_line_buffer
// Simple dual-port RAM holding one horizontally-reduced row of the pooling
// window. Written on even rows, read on odd rows; 1-cycle registered read
// so it maps onto block RAM.
// Ports:
//   clk_i      clock
//   wr_en_i    write strobe
//   wr_addr_i  write address (output column)
//   wr_data_i  write data (all engines, packed)
//   rd_en_i    read strobe; rd_data_o updates on the next edge and holds otherwise
//   rd_addr_i  read address (output column)
//   rd_data_o  registered read data
module pool_line_buffer
    import pool_pkg::*;
#(
    parameter int Depth = 8191,
    parameter int Width = 16,
    parameter int AddrW = AddrWidth(Depth)
) (
    input  logic             clk_i,
    input  logic             wr_en_i,
    input  logic [AddrW-1:0] wr_addr_i,
    input  logic [Width-1:0] wr_data_i,
    input  logic             rd_en_i,
    input  logic [AddrW-1:0] rd_addr_i,
    output logic [Width-1:0] rd_data_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] rdData_q;

    // No reset on the array or read register so the tools can use block RAM.
    // Read data holds between reads, which lets input bubbles sit between the
    // pair-load beat and the completing beat.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rdData_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rdData_q;

endmodule

// File: rtl/max_pool_layer.sv
// max_pool_layer
// Streaming 2x2/stride-2 pooling of a raster-order multi-engine stream.
// All engines are pooled in lock-step from a shared valid; each completed
// 2x2 window produces one registered output beat per engine.
// Build option: define AVG_POOL_EN to add pool_mode_i (0 = max, 1 = average).
// Ports:
//   clk_i          clock
//   rst_i          asynchronous active-high reset
//   en_i           stage enable; low freezes all state and ignores inputs
//   matrix_size_i  input row width W, sampled on the first beat of a frame
//   data_i         EngineCount packed signed N-bit inputs
//   valid_i        data_i valid
//   done_i         upstream frame complete
//   pool_mode_i    (AVG_POOL_EN only) 0 = max, 1 = average, sampled at frame start
//   data_o         EngineCount packed signed N-bit pooled outputs
//   valid_o        one-cycle pulse per pooled beat
//   done_o         frame pooled and drained; held until reset
module max_pool_layer
    import pool_pkg::*;
#(
    parameter int MaxMatrixSize = 16383,
    parameter int EngineCount   = 1023,
    parameter int N             = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     en_i,
    input  logic [SizeW-1:0]         matrix_size_i,
    input  logic [N*EngineCount-1:0] data_i,
    input  logic                     valid_i,
    input  logic                     done_i,
`ifdef AVG_POOL_EN
    input  logic                     pool_mode_i,
`endif
    output logic [N*EngineCount-1:0] data_o,
    output logic                     valid_o,
    output logic                     done_o
);

    localparam int DataW = N * EngineCount;
    localparam int Depth = LineBufDepth(MaxMatrixSize);
    localparam int AddrW = AddrWidth(Depth);
`ifdef AVG_POOL_EN
    // Average mode keeps the full horizontal sum, so one extra bit per engine.
    localparam int BufW = N + 1;
`else
    localparam int BufW = N;
`endif

    pool_state_t        state_q;
    logic [SizeW-1:0]   col_q;
    logic [SizeW-1:0]   width_q;
    logic [DataW-1:0]   pairReg_q;
    logic [DataW-1:0]   data_q;
    logic               valid_q;
    logic               done_q;

    logic [SizeW-1:0]        widthEff;
    logic [SizeW-1:0]        pairLimit;
    logic                    colLast;
    logic                    accept;
    logic                    rowOdd;
    logic                    isPairLoad;
    logic                    isComplete;
    logic                    lineRe;
    logic                    lineWe;
    logic [AddrW-1:0]        lineAddr;
    logic [EngineCount*BufW-1:0] lineWrData;
    logic [EngineCount*BufW-1:0] lineRdData;
    logic [DataW-1:0]        data_d;

`ifdef AVG_POOL_EN
    logic poolMode_q;
    logic modeAvg;
    assign modeAvg = (state_q == IDLE) ? pool_mode_i : poolMode_q;
`endif

    // The first beat of a frame arrives in IDLE and must already use the new
    // width, so the live port value stands in for the latched one there.
    assign widthEff   = (state_q == IDLE) ? matrix_size_i : width_q;
    assign pairLimit  = {widthEff[SizeW-1:1], 1'b0};
    assign colLast    = (col_q == widthEff - 1'b1);
    assign accept     = en_i && valid_i && (state_q != DONE);
    assign rowOdd     = (state_q == ODD_ROW);
    assign isPairLoad = ~col_q[0];
    assign isComplete = col_q[0] && (col_q < pairLimit);

    // The read is issued one beat early, on the pair-load beat, and skipped for
    // the dangling column of an odd-width row so the address stays in range.
    assign lineRe   = accept && isPairLoad && ({col_q[SizeW-1:1], 1'b1} < pairLimit);
    assign lineWe   = accept && isComplete && !rowOdd;
    assign lineAddr = AddrW'(col_q >> 1);

    for (genvar e = 0; e < EngineCount; e++) begin : g_engine
        logic signed [N-1:0]    pairVal;
        logic signed [N-1:0]    inVal;
        logic signed [BufW-1:0] lineVal;
        logic signed [N-1:0]    hMax;
        logic signed [N-1:0]    vMax;

        assign pairVal = pairReg_q[e*N +: N];
        assign inVal   = data_i[e*N +: N];
        assign lineVal = lineRdData[e*BufW +: BufW];
        assign hMax    = N'(max2(MaxDataW'(pairVal), MaxDataW'(inVal)));
        assign vMax    = N'(max2(MaxDataW'(hMax), MaxDataW'(lineVal)));

`ifdef AVG_POOL_EN
        logic signed [N:0]   hSum;
        logic signed [N+1:0] vSum;

        // Arithmetic shift floors toward -inf, matching a true floor average.
        assign hSum = (N+1)'(pairVal) + (N+1)'(inVal);
        assign vSum = (N+2)'(hSum) + (N+2)'(lineVal);
        assign lineWrData[e*BufW +: BufW] = modeAvg ? hSum : BufW'(hMax);
        assign data_d[e*N +: N]           = modeAvg ? N'(vSum >>> 2) : vMax;
`else
        assign lineWrData[e*BufW +: BufW] = hMax;
        assign data_d[e*N +: N]           = vMax;
`endif
    end

    pool_line_buffer #(
        .Depth (Depth),
        .Width (EngineCount * BufW),
        .AddrW (AddrW)
    ) u_line_buffer (
        .clk_i     (clk_i),
        .wr_en_i   (lineWe),
        .wr_addr_i (lineAddr),
        .wr_data_i (lineWrData),
        .rd_en_i   (lineRe),
        .rd_addr_i (lineAddr),
        .rd_data_o (lineRdData)
    );

    // Frame FSM with registered outputs. valid_o is a pulse and clears every
    // cycle even while disabled, so a held enable never duplicates a beat.
    // done_i wins over the row toggle, but the beat it arrives with is still
    // processed, so the last pooled value is issued on the same edge that
    // enters DONE and done_o follows one cycle later.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            col_q      <= '0;
            width_q    <= '0;
            pairReg_q  <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
`ifdef AVG_POOL_EN
            poolMode_q <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            if (en_i) begin
                if (state_q == DONE) begin
                    done_q <= 1'b1;
                end
                if (accept) begin
                    col_q <= colLast ? '0 : col_q + 1'b1;
                    if (isPairLoad) begin
                        pairReg_q <= data_i;
                    end
                    if (isComplete && rowOdd) begin
                        data_q  <= data_d;
                        valid_q <= 1'b1;
                    end
                    case (state_q)
                        IDLE: begin
                            width_q <= matrix_size_i;
`ifdef AVG_POOL_EN
                            poolMode_q <= pool_mode_i;
`endif
                            state_q <= colLast ? ODD_ROW : EVEN_ROW;
                        end
                        EVEN_ROW: if (colLast) state_q <= ODD_ROW;
                        ODD_ROW:  if (colLast) state_q <= EVEN_ROW;
                        default:  ;
                    endcase
                end
                if (done_i && state_q != DONE) begin
                    state_q <= DONE;
                end
            end
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign done_o  = done_q;

endmodule
